kernel_2mm_hls: RTL and testbench

// - PolyBench 2mm accelerator: tmp = alpha*A*B; D = beta*D + tmp*C, 32-bit integer math.
// - All operands live in one external 8192x32 word memory reached via two BRAM-style ports (0,1).
// - ap_ctrl_hs-style start/done; sits under the host-memory bridge that services every ce cycle.

---
 rtl/kernel_2mm_hls.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_kernel_2mm_hls.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_2mm_hls.sv
// kernel_2mm_hls -- PolyBench 2mm accelerator: tmp = alpha*A*B; D = beta*D + tmp*C
// (32-bit two's complement, results truncated modulo 2^32).
//
// All operands live in one external word memory. The block reaches that memory
// through two BRAM-style ports. Port 0 reads and writes. Port 1 only reads.
// Row-major word layout: ALPHA=0, BETA=1, A at 16, then B, tmp, C and D packed behind it.
//
// Ports:
//   mod_clk, reset        clock; asynchronous active-high reset
//   ap_start              level start request (sampled in IDLE and FIN)
//   ap_done / ap_ready    one-cycle completion pulse (same signal)
//   ap_idle               high while not running
//   indata_address0/1     word address, port 0/1 (registered)
//   indata_ce0/1          access enable (registered)
//   indata_we0/1          write enable, port 1 always 0
//   indata_d0/1           write data, port 1 always 0
//   indata_q0/1           read data, valid the edge after the memory samples ce
//   access_cnt            only with KERNEL_2MM_ACCESS_CNT_EN: cycles with ce0|ce1 high,
//                         cleared on reset and on each LD_SC entry
//
// Optional feature macro: KERNEL_2MM_ACCESS_CNT_EN

module kernel_2mm_hls #(
  parameter int unsigned NI       = 16,
  parameter int unsigned NK       = 16,
  parameter int unsigned NJ       = 16,
  parameter int unsigned NL       = 16,
  parameter int unsigned ADDR_WID = 13,
  parameter int unsigned DATA_WID = 32
) (
  input  logic                mod_clk,
  input  logic                reset,
  input  logic                ap_start,
  output logic                ap_done,
  output logic                ap_idle,
  output logic                ap_ready,
  output logic [ADDR_WID-1:0] indata_address0,
  output logic                indata_ce0,
  output logic                indata_we0,
  output logic [DATA_WID-1:0] indata_d0,
  input  logic [DATA_WID-1:0] indata_q0,
  output logic [ADDR_WID-1:0] indata_address1,
  output logic                indata_ce1,
  output logic                indata_we1,
  output logic [DATA_WID-1:0] indata_d1,
  input  logic [DATA_WID-1:0] indata_q1
`ifdef KERNEL_2MM_ACCESS_CNT_EN
  ,
  output logic [31:0]         access_cnt
`endif
);

  typedef logic [ADDR_WID-1:0] addr_t;
  typedef logic [DATA_WID-1:0] data_t;

  localparam addr_t ALPHA_ADDR = addr_t'(0);
  localparam addr_t BETA_ADDR  = addr_t'(1);
  localparam addr_t A_BASE     = addr_t'(16);
  localparam addr_t B_BASE     = addr_t'(16 + NI*NK);
  localparam addr_t T_BASE     = addr_t'(16 + NI*NK + NK*NJ);
  localparam addr_t C_BASE     = addr_t'(16 + NI*NK + NK*NJ + NI*NJ);
  localparam addr_t D_BASE     = addr_t'(16 + NI*NK + NK*NJ + NI*NJ + NJ*NL);

  localparam addr_t NK_A    = addr_t'(NK);
  localparam addr_t NJ_A    = addr_t'(NJ);
  localparam addr_t NL_A    = addr_t'(NL);
  localparam addr_t NI_M1   = addr_t'(NI - 1);
  localparam addr_t NK_M1   = addr_t'(NK - 1);
  localparam addr_t NJ_M1   = addr_t'(NJ - 1);
  localparam addr_t NL_M1   = addr_t'(NL - 1);
  localparam addr_t IDX_ONE = addr_t'(1);

  // *_RD: operand read visible to memory; *_MAC: read data consumed.
  // The next read is issued from the consume cycle, so one MAC takes two cycles.
  typedef enum logic [3:0] {
    S_IDLE, S_LD_SC, S_LD_LAT,
    S_M1_RD, S_M1_MAC, S_M1_WR,
    S_M2_DRD, S_M2_DLD, S_M2_RD, S_M2_MAC, S_M2_WR,
    S_FIN
  } state_t;

  state_t r_state, w_state;
  addr_t  r_i, r_j, r_k, r_l, w_i, w_j, w_k, w_l;
  data_t  r_alpha, r_beta, r_acc, w_alpha, w_beta, w_acc, w_sum;
  logic   r_ce0, r_ce1, r_we0, w_ce0, w_ce1, w_we0;
  addr_t  r_addr0, r_addr1, w_addr0, w_addr1;
  data_t  r_d0, w_d0;
  logic   r_done, r_idle, w_done, w_idle;

  always_ff @(posedge mod_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_l     <= '0;
      r_alpha <= '0;
      r_beta  <= '0;
      r_acc   <= '0;
      r_ce0   <= 1'b0;
      r_ce1   <= 1'b0;
      r_we0   <= 1'b0;
      r_addr0 <= '0;
      r_addr1 <= '0;
      r_d0    <= '0;
      r_done  <= 1'b0;
      r_idle  <= 1'b1;
    end else begin
      r_state <= w_state;
      r_i     <= w_i;
      r_j     <= w_j;
      r_k     <= w_k;
      r_l     <= w_l;
      r_alpha <= w_alpha;
      r_beta  <= w_beta;
      r_acc   <= w_acc;
      r_ce0   <= w_ce0;
      r_ce1   <= w_ce1;
      r_we0   <= w_we0;
      r_addr0 <= w_addr0;
      r_addr1 <= w_addr1;
      r_d0    <= w_d0;
      r_done  <= w_done;
      r_idle  <= w_idle;
    end
  end

  always_comb begin
    w_state = r_state;
    w_i     = r_i;
    w_j     = r_j;
    w_k     = r_k;
    w_l     = r_l;
    w_alpha = r_alpha;
    w_beta  = r_beta;
    w_acc   = r_acc;
    w_sum   = '0;
    w_ce0   = 1'b0;
    w_ce1   = 1'b0;
    w_we0   = 1'b0;
    w_addr0 = r_addr0;
    w_addr1 = r_addr1;
    w_d0    = r_d0;
    w_done  = 1'b0;
    w_idle  = r_idle;
    unique case (r_state)
      S_IDLE: begin
        if (ap_start) begin
          w_state = S_LD_SC;
          w_idle  = 1'b0;
          w_ce0   = 1'b1;
          w_ce1   = 1'b1;
          w_addr0 = ALPHA_ADDR;
          w_addr1 = BETA_ADDR;
        end
      end
      S_LD_SC: w_state = S_LD_LAT;
      S_LD_LAT: begin
        w_alpha = indata_q0;
        w_beta  = indata_q1;
        w_i     = '0;
        w_j     = '0;
        w_k     = '0;
        w_acc   = '0;
        w_ce0   = 1'b1;
        w_ce1   = 1'b1;
        w_addr0 = A_BASE;
        w_addr1 = B_BASE;
        w_state = S_M1_RD;
      end
      S_M1_RD: w_state = S_M1_MAC;
      S_M1_MAC: begin
        w_sum = r_acc + r_alpha * indata_q0 * indata_q1;
        w_acc = w_sum;
        if (r_k == NK_M1) begin
          w_ce0   = 1'b1;
          w_we0   = 1'b1;
          w_addr0 = T_BASE + r_i * NJ_A + r_j;
          w_d0    = w_sum;
          w_state = S_M1_WR;
        end else begin
          w_k     = r_k + IDX_ONE;
          w_ce0   = 1'b1;
          w_ce1   = 1'b1;
          w_addr0 = A_BASE + r_i * NK_A + w_k;
          w_addr1 = B_BASE + w_k * NJ_A + r_j;
          w_state = S_M1_RD;
        end
      end
      S_M1_WR: begin
        w_acc = '0;
        w_k   = '0;
        if (r_i == NI_M1 && r_j == NJ_M1) begin
          w_i     = '0;
          w_j     = '0;
          w_l     = '0;
          w_ce0   = 1'b1;
          w_addr0 = D_BASE;
          w_state = S_M2_DRD;
        end else begin
          w_j     = (r_j == NJ_M1) ? '0 : r_j + IDX_ONE;
          w_i     = (r_j == NJ_M1) ? r_i + IDX_ONE : r_i;
          w_ce0   = 1'b1;
          w_ce1   = 1'b1;
          w_addr0 = A_BASE + w_i * NK_A;
          w_addr1 = B_BASE + w_j;
          w_state = S_M1_RD;
        end
      end
      S_M2_DRD: w_state = S_M2_DLD;
      S_M2_DLD: begin
        w_acc   = r_beta * indata_q0;
        w_j     = '0;
        w_ce0   = 1'b1;
        w_ce1   = 1'b1;
        w_addr0 = T_BASE + r_i * NJ_A;
        w_addr1 = C_BASE + r_l;
        w_state = S_M2_RD;
      end
      S_M2_RD: w_state = S_M2_MAC;
      S_M2_MAC: begin
        w_sum = r_acc + indata_q0 * indata_q1;
        w_acc = w_sum;
        if (r_j == NJ_M1) begin
          w_ce0   = 1'b1;
          w_we0   = 1'b1;
          w_addr0 = D_BASE + r_i * NL_A + r_l;
          w_d0    = w_sum;
          w_state = S_M2_WR;
        end else begin
          w_j     = r_j + IDX_ONE;
          w_ce0   = 1'b1;
          w_ce1   = 1'b1;
          w_addr0 = T_BASE + r_i * NJ_A + w_j;
          w_addr1 = C_BASE + w_j * NL_A + r_l;
          w_state = S_M2_RD;
        end
      end
      S_M2_WR: begin
        w_j = '0;
        if (r_i == NI_M1 && r_l == NL_M1) begin
          w_i     = '0;
          w_l     = '0;
          w_done  = 1'b1;
          w_state = S_FIN;
        end else begin
          w_l     = (r_l == NL_M1) ? '0 : r_l + IDX_ONE;
          w_i     = (r_l == NL_M1) ? r_i + IDX_ONE : r_i;
          w_ce0   = 1'b1;
          w_addr0 = D_BASE + w_i * NL_A + w_l;
          w_state = S_M2_DRD;
        end
      end
      S_FIN: begin
        if (ap_start) begin
          w_state = S_LD_SC;
          w_ce0   = 1'b1;
          w_ce1   = 1'b1;
          w_addr0 = ALPHA_ADDR;
          w_addr1 = BETA_ADDR;
        end else begin
          w_state = S_IDLE;
          w_idle  = 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_idle  = 1'b1;
      end
    endcase
  end

  assign ap_done         = r_done;
  assign ap_ready        = r_done;
  assign ap_idle         = r_idle;
  assign indata_address0 = r_addr0;
  assign indata_ce0      = r_ce0;
  assign indata_we0      = r_we0;
  assign indata_d0       = r_d0;
  assign indata_address1 = r_addr1;
  assign indata_ce1      = r_ce1;
  assign indata_we1      = 1'b0;
  assign indata_d1       = '0;

`ifdef KERNEL_2MM_ACCESS_CNT_EN
  logic [31:0] r_access_cnt;

  always_ff @(posedge mod_clk or posedge reset) begin
    if (reset)
      r_access_cnt <= '0;
    else if (w_state == S_LD_SC && r_state != S_LD_SC)
      r_access_cnt <= '0;
    else if (r_ce0 | r_ce1)
      r_access_cnt <= r_access_cnt + 32'd1;
  end

  assign access_cnt = r_access_cnt;
`endif

endmodule

// File: tb/tb_kernel_2mm_hls.sv
// tb_kernel_2mm_hls -- directed bench for kernel_2mm_hls with a behavioural
// 8192x32 two-port memory (port 0 read/write, port 1 read).
module tb_kernel_2mm_hls;

  localparam int A_B   = 16;
  localparam int B_B   = 272;
  localparam int T_B   = 528;
  localparam int C_B   = 784;
  localparam int D_B   = 1040;
  localparam int D_END = 1295;
  localparam int LAT_MAX = 4 * (16*16*16 + 16*16*16) + 64;
  localparam logic [31:0] POISON = 32'hBAD0_0BAD;

  logic        mod_clk = 1'b0;
  logic        reset;
  logic        ap_start;
  logic        ap_done, ap_idle, ap_ready;
  logic [12:0] indata_address0, indata_address1;
  logic        indata_ce0, indata_we0, indata_ce1, indata_we1;
  logic [31:0] indata_d0, indata_d1;
  logic [31:0] indata_q0, indata_q1;
`ifdef KERNEL_2MM_ACCESS_CNT_EN
  logic [31:0] access_cnt;
`endif

  logic [31:0] mem [0:8191];
  logic [31:0] exp_t [0:255];
  logic [31:0] exp_d [0:255];

  int checks = 0;
  int failures = 0;
  int prot_err = 0;
  int done_cnt = 0;

  kernel_2mm_hls #(.NI(16), .NK(16), .NJ(16), .NL(16), .ADDR_WID(13), .DATA_WID(32)) dut (
    .mod_clk         (mod_clk),
    .reset           (reset),
    .ap_start        (ap_start),
    .ap_done         (ap_done),
    .ap_idle         (ap_idle),
    .ap_ready        (ap_ready),
    .indata_address0 (indata_address0),
    .indata_ce0      (indata_ce0),
    .indata_we0      (indata_we0),
    .indata_d0       (indata_d0),
    .indata_q0       (indata_q0),
    .indata_address1 (indata_address1),
    .indata_ce1      (indata_ce1),
    .indata_we1      (indata_we1),
    .indata_d1       (indata_d1),
    .indata_q1       (indata_q1)
`ifdef KERNEL_2MM_ACCESS_CNT_EN
    ,
    .access_cnt      (access_cnt)
`endif
  );

  always #5 mod_clk = ~mod_clk;

  // Memory: q only carries data in the cycle after an access; otherwise it is
  // poisoned so that sampling on the wrong edge corrupts the result.
  always @(posedge mod_clk) begin
    if (indata_ce0 === 1'b1 && indata_we0 === 1'b1) begin
      mem[int'(indata_address0)] = indata_d0;
      indata_q0 <= POISON;
    end else if (indata_ce0 === 1'b1)
      indata_q0 <= mem[int'(indata_address0)];
    else
      indata_q0 <= POISON;
    if (indata_ce1 === 1'b1)
      indata_q1 <= mem[int'(indata_address1)];
    else
      indata_q1 <= POISON;
  end

  // Protocol monitor: port 1 never writes, accesses stay inside the layout,
  // writes land only in tmp or D, no read/write address collision.
  always @(posedge mod_clk) begin
    if (indata_we1 !== 1'b0) prot_err++;
    if (indata_ce0 === 1'b1 && int'(indata_address0) > D_END) prot_err++;
    if (indata_ce1 === 1'b1 && int'(indata_address1) > D_END) prot_err++;
    if (indata_ce0 === 1'b1 && indata_we0 === 1'b1) begin
      if (!((int'(indata_address0) >= T_B && int'(indata_address0) < C_B) ||
            (int'(indata_address0) >= D_B && int'(indata_address0) <= D_END)))
        prot_err++;
      if (indata_ce1 === 1'b1 && indata_address1 == indata_address0) prot_err++;
    end
  end

  always @(negedge mod_clk) if (ap_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  task automatic fill(input logic [31:0] al, input logic [31:0] be, input logic [31:0] av,
                      input logic [31:0] bv, input logic [31:0] cv, input logic [31:0] dv);
    mem[0] = al;
    mem[1] = be;
    for (int n = 0; n < 256; n++) begin
      mem[A_B + n] = av;
      mem[B_B + n] = bv;
      mem[T_B + n] = 32'hDEAD_BEEF;
      mem[C_B + n] = cv;
      mem[D_B + n] = dv;
    end
  endtask

  task automatic set_exp(input logic [31:0] tv, input logic [31:0] dv);
    for (int n = 0; n < 256; n++) begin
      exp_t[n] = tv;
      exp_d[n] = dv;
    end
  endtask

  // Compares the first differing element (or element 0 when all match).
  task automatic chk_region(input string tag, input bit is_d);
    int idx;
    idx = 0;
    for (int n = 255; n >= 0; n--)
      if (is_d ? (mem[D_B + n] !== exp_d[n]) : (mem[T_B + n] !== exp_t[n])) idx = n;
    if (is_d) chk($sformatf("%s_D[%0d]", tag, idx), mem[D_B + idx], exp_d[idx]);
    else      chk($sformatf("%s_tmp[%0d]", tag, idx), mem[T_B + idx], exp_t[idx]);
  endtask

  task automatic run_once(input string tag);
    int n;
    int cyc;
    int d0;
    int p0;
    d0 = done_cnt;
    p0 = prot_err;
    @(negedge mod_clk);
    ap_start = 1'b1;
    n = 0;
    while (ap_idle !== 1'b0 && n < 10) begin
      @(negedge mod_clk);
      n++;
    end
    ap_start = 1'b0;
    cyc = 0;
    while (ap_done !== 1'b1 && cyc < 40000) begin
      @(negedge mod_clk);
      cyc++;
    end
    chk({tag, "_done_seen"}, {31'd0, ap_done}, 32'd1);
    chk({tag, "_ready_eq_done"}, {31'd0, ap_ready}, 32'd1);
    chk({tag, "_latency_ok"}, {31'd0, cyc < LAT_MAX}, 32'd1);
    repeat (3) @(negedge mod_clk);
    chk({tag, "_done_pulses"}, done_cnt - d0, 32'd1);
    chk({tag, "_idle_after"}, {31'd0, ap_idle}, 32'd1);
    chk({tag, "_protocol"}, prot_err - p0, 32'd0);
    chk_region(tag, 1'b0);
    chk_region(tag, 1'b1);
  endtask

  initial begin
    int n;
    int d0;
    reset = 1'b1;
    ap_start = 1'b0;
    indata_q0 = '0;
    indata_q1 = '0;
    repeat (3) @(negedge mod_clk);
    chk("rst_idle", {31'd0, ap_idle}, 32'd1);
    chk("rst_done", {31'd0, ap_done}, 32'd0);
    chk("rst_ready", {31'd0, ap_ready}, 32'd0);
    chk("rst_ce", {30'd0, indata_ce0, indata_ce1}, 32'd0);
    chk("rst_we", {30'd0, indata_we0, indata_we1}, 32'd0);
    chk("rst_addr0", {19'd0, indata_address0}, 32'd0);
    chk("rst_d0", indata_d0, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge mod_clk);

    // All-ones
    fill(32'd1, 32'd0, 32'd1, 32'd1, 32'd1, 32'd7);
    set_exp(32'd16, 32'd256);
    run_once("ones");
`ifdef KERNEL_2MM_ACCESS_CNT_EN
    chk("access_cnt", access_cnt, 32'd8961);
`endif

    // Scalars
    fill(32'd2, 32'd3, 32'd1, 32'd1, 32'd1, 32'd1);
    set_exp(32'd32, 32'd515);
    run_once("scal");

    // Identity: A=I, B=M, C=I, D=0 -> tmp=M, D=M
    fill(32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0);
    for (int r = 0; r < 16; r++) begin
      mem[A_B + r*16 + r] = 32'd1;
      mem[C_B + r*16 + r] = 32'd1;
      for (int c = 0; c < 16; c++) begin
        mem[B_B + r*16 + c] = 32'(r*16 + c);
        exp_t[r*16 + c] = 32'(r*16 + c);
        exp_d[r*16 + c] = 32'(r*16 + c);
      end
    end
    run_once("ident");

    // Wrap: 0x10000*1*1 summed 16x; C=0 keeps D
    fill(32'h0001_0000, 32'd1, 32'd1, 32'd1, 32'd0, 32'd5);
    set_exp(32'h0010_0000, 32'd5);
    run_once("wrap1");
    // Wrap: alpha*A = 2^32 -> 0
    fill(32'h0001_0000, 32'd1, 32'h0001_0000, 32'd1, 32'd1, 32'd5);
    set_exp(32'd0, 32'd5);
    run_once("wrap2");

    // ap_start held high: two back-to-back runs, D grows by NJ*tmp each run
    fill(32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0);
    set_exp(32'd16, 32'd512);
    d0 = done_cnt;
    @(negedge mod_clk);
    ap_start = 1'b1;
    n = 0;
    while (n < 2 && done_cnt - d0 < 40000) begin
      @(negedge mod_clk);
      if (ap_done === 1'b1) n++;
      if (ap_idle === 1'b1 && n == 1) n = 10;
      if (done_cnt - d0 == 0 && $time > 64'd2000000) n = 20;
    end
    ap_start = 1'b0;
    chk("restart_two_runs", n, 32'd2);
    repeat (3) @(negedge mod_clk);
    chk("restart_idle_after", {31'd0, ap_idle}, 32'd1);
    chk_region("restart", 1'b0);
    chk_region("restart", 1'b1);

    // Reset mid-MM1 aborts at once; fresh run afterwards is correct
    fill(32'd1, 32'd0, 32'd1, 32'd1, 32'd1, 32'd7);
    @(negedge mod_clk);
    ap_start = 1'b1;
    @(negedge mod_clk);
    ap_start = 1'b0;
    repeat (200) @(negedge mod_clk);
    chk("midrun_busy", {31'd0, ap_idle}, 32'd0);
    reset = 1'b1;
    #1;
    chk("midrst_ce", {30'd0, indata_ce0, indata_ce1}, 32'd0);
    chk("midrst_idle", {31'd0, ap_idle}, 32'd1);
    chk("midrst_done", {31'd0, ap_done}, 32'd0);
    repeat (2) @(negedge mod_clk);
    reset = 1'b0;
    repeat (2) @(negedge mod_clk);
    fill(32'd1, 32'd0, 32'd1, 32'd1, 32'd1, 32'd7);
    set_exp(32'd16, 32'd256);
    run_once("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
